// File: rtl/pll_lock_mgr_if.sv
// Signal bundle between the PLL lock manager and the surrounding system.
// The slave side is the manager; the master side drives lock and restart.
interface pll_lock_mgr_if #(
   parameter int NUM_CE = 2
);
   logic              extlock;
   logic              restart;
   logic              pll_reset;
   logic              sys_rst_n;
   logic              locked;
   logic [NUM_CE-1:0] ce;
   logic [7:0]        relock_cnt;
   logic              timeout_err;

   modport master (
      output extlock, restart,
      input  pll_reset, sys_rst_n, locked, ce, relock_cnt, timeout_err
   );

   modport slave (
      input  extlock, restart,
      output pll_reset, sys_rst_n, locked, ce, relock_cnt, timeout_err
   );
endinterface

// File: rtl/pll_lock_mgr.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies lock, releases the
// downstream reset and generates divided clock-enable strobes while running.
//
// state     | meaning
// ----------+------------------------------------------------------------
// PLL_RST   | PLL reset asserted for RST_PULSE cycles
// WAIT_LOCK | waiting for LOCK_STABLE consecutive lock cycles, with timeout
// RELEASE   | lock declared, holding sys_rst_n low for RELEASE_DLY cycles
// RUN       | sys_rst_n released, ce strobes active, watching for lock loss
module pll_lock_mgr #(
   parameter int                   RST_PULSE    = 16,
   parameter int                   LOCK_STABLE  = 1024,
   parameter int                   LOCK_TIMEOUT = 65536,
   parameter int                   RELEASE_DLY  = 256,
   parameter int                   NUM_CE       = 2,
   parameter logic [NUM_CE*16-1:0] CE_DIV       = {16'd100, 16'd10}
) (
   input logic          clk,
   input logic          rst_n,
   pll_lock_mgr_if.slave bus
);

   localparam int CNT_MAX_A = (RST_PULSE > RELEASE_DLY) ? RST_PULSE : RELEASE_DLY;
   localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT) ? CNT_MAX_A : LOCK_TIMEOUT;
   localparam int CNT_W     = $clog2(CNT_MAX);
   localparam int STAB_W    = $clog2(LOCK_STABLE + 1);

   localparam logic [CNT_W-1:0]  RST_TC  = CNT_W'(RST_PULSE - 1);
   localparam logic [CNT_W-1:0]  TMO_TC  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  REL_TC  = CNT_W'(RELEASE_DLY - 1);
   localparam logic [STAB_W-1:0] STAB_TC = STAB_W'(LOCK_STABLE - 1);

   typedef enum logic [1:0] {
      PLL_RST   = 2'd0,
      WAIT_LOCK = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                sync1_q, lock_q;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [STAB_W-1:0]   stab_q, stab_d;
   logic [7:0]          relock_q, relock_d;
   logic                timeout_err_q, timeout_err_d;
   logic                sys_rst_n_q, sys_rst_n_d;
   logic                timeout_hit;
   logic [NUM_CE-1:0]   ce_hit;

   // extlock comes from the PLL domain; only lock_q is used downstream
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         lock_q  <= 1'b0;
      end else begin
         sync1_q <= bus.extlock;
         lock_q  <= sync1_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= PLL_RST;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      timeout_hit = 1'b0;
      case (state_q)
         PLL_RST: begin
            if (cnt_q == RST_TC) state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (lock_q && (stab_q == STAB_TC)) begin
               state_d = RELEASE;
            end else if (cnt_q == TMO_TC) begin
               state_d     = PLL_RST;
               timeout_hit = 1'b1;
            end
         end
         RELEASE: begin
            if (!lock_q)               state_d = PLL_RST;
            else if (cnt_q == REL_TC)  state_d = RUN;
         end
         RUN: begin
            if (!lock_q) state_d = PLL_RST;
         end
         default: state_d = PLL_RST;
      endcase
      if (bus.restart && (state_q != PLL_RST)) state_d = PLL_RST;
   end

   always_comb begin
      bus.pll_reset = (state_q == PLL_RST);
      bus.locked    = (state_q == RELEASE) || (state_q == RUN);
      bus.ce        = (state_q == RUN) ? ce_hit : '0;
   end

   always_comb begin
      cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);

      stab_d = '0;
      if ((state_q == WAIT_LOCK) && (state_d == WAIT_LOCK) && lock_q) begin
         stab_d = stab_q + STAB_W'(1);
      end

      relock_d = relock_q;
      if ((state_q == RUN) && !lock_q && (relock_q != 8'hFF)) begin
         relock_d = relock_q + 8'd1;
      end

      timeout_err_d = timeout_err_q | timeout_hit;
      // registered so that it is low on the very first PLL_RST cycle
      sys_rst_n_d   = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         stab_q        <= '0;
         relock_q      <= 8'd0;
         timeout_err_q <= 1'b0;
         sys_rst_n_q   <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         stab_q        <= stab_d;
         relock_q      <= relock_d;
         timeout_err_q <= timeout_err_d;
         sys_rst_n_q   <= sys_rst_n_d;
      end
   end

   assign bus.sys_rst_n   = sys_rst_n_q;
   assign bus.relock_cnt  = relock_q;
   assign bus.timeout_err = timeout_err_q;

   for (genvar g = 0; g < NUM_CE; g++) begin : g_ce
      localparam logic [15:0] DIV_TC = CE_DIV[16*g +: 16] - 16'd1;

      logic [15:0] ce_cnt_q, ce_cnt_d;

      // the counter sits at 0 on the first RUN cycle, so the first strobe
      // lands on RUN cycle CE_DIV
      always_comb begin
         if ((state_q != RUN) || (state_d != RUN)) begin
            ce_cnt_d = 16'd0;
         end else if (ce_cnt_q == DIV_TC) begin
            ce_cnt_d = 16'd0;
         end else begin
            ce_cnt_d = ce_cnt_q + 16'd1;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            ce_cnt_q <= 16'd0;
         end else begin
            ce_cnt_q <= ce_cnt_d;
         end
      end

      assign ce_hit[g] = (ce_cnt_q == DIV_TC);
   end

endmodule
